// File: rtl/llr_fg_stage_pkg.sv
// llr_fg_stage_pkg: shared constants and types for the f/g LLR update stage
package llr_fg_stage_pkg;
  localparam int PROCESS_UNIT_LLR_NUM = 16;
  localparam int LLR_INTERNAL_LEN = 6;
  localparam int LLR_MAX_POS = 2 ** (LLR_INTERNAL_LEN - 1) - 1;
  localparam int LLR_MAX_NEG = -LLR_MAX_POS;
  typedef enum logic {MODE_F = 1'b0, MODE_G = 1'b1} mode_t;
  function automatic int llr_max(input int w);
    return 2 ** (w - 1) - 1;
  endfunction
endpackage

// File: rtl/llr_fg_pe.sv
// llr_fg_pe: single-lane unsaturated f (min-sum) / g LLR arithmetic
module llr_fg_pe
  import llr_fg_stage_pkg::*;
#(
  parameter int LLR_W = LLR_INTERNAL_LEN
) (
  input  logic [LLR_W-1:0] a,
  input  logic [LLR_W-1:0] b,
  input  logic             beta,
  input  mode_t            mode,
  output logic [LLR_W:0]   res
);
  logic signed [LLR_W:0] ax, bx, aa, ba, mn;
  always_comb begin
    ax = $signed({a[LLR_W-1], a});
    bx = $signed({b[LLR_W-1], b});
    aa = ax[LLR_W] ? -ax : ax;
    ba = bx[LLR_W] ? -bx : bx;
    mn = aa < ba ? aa : ba;
    // one extra bit holds |most-negative| and the full g range; S2 saturates
    res = mode == MODE_G ? (beta ? bx - ax : bx + ax) : (a[LLR_W-1] ^ b[LLR_W-1] ? -mn : mn);
  end
endmodule

// File: rtl/llr_fg_stage.sv
// llr_fg_stage: two-stage pipelined f/g LLR update with valid/ready on both sides
module llr_fg_stage
  import llr_fg_stage_pkg::*;
#(
  parameter int LLR_NUM = PROCESS_UNIT_LLR_NUM,
  parameter int LLR_W = LLR_INTERNAL_LEN,
  parameter int TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [2*LLR_NUM*LLR_W-1:0] in_alpha,
  input  logic [LLR_NUM-1:0]         in_beta,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LLR_NUM*LLR_W-1:0]   out_llr,
  output logic [TAG_W-1:0]           out_tag
);
  localparam logic signed [LLR_W:0] MAXP = (LLR_W + 1)'(llr_max(LLR_W));
  localparam logic signed [LLR_W:0] MINN = -MAXP;
  logic [LLR_NUM-1:0][LLR_W:0] pe_res, s1_res;
  logic [LLR_NUM*LLR_W-1:0] sat_llr;
  logic [TAG_W-1:0] s1_tag;
  logic s1_valid, s1_adv, s2_adv;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  for (genvar i = 0; i < LLR_NUM; i++) begin : g_lane
    llr_fg_pe #(.LLR_W(LLR_W)) u_pe (
      .a   (in_alpha[(2*LLR_NUM-1-i)*LLR_W +: LLR_W]),
      .b   (in_alpha[(LLR_NUM-1-i)*LLR_W +: LLR_W]),
      .beta(in_beta[LLR_NUM-1-i]),
      .mode(mode_t'(in_mode)),
      .res (pe_res[i])
    );
    // symmetric clamp: the most-negative code is never emitted
    assign sat_llr[(LLR_NUM-1-i)*LLR_W +: LLR_W] =
      $signed(s1_res[i]) > MAXP ? MAXP[LLR_W-1:0] :
      $signed(s1_res[i]) < MINN ? MINN[LLR_W-1:0] : s1_res[i][LLR_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_res <= '0;
      s1_tag <= '0;
      out_valid <= 1'b0;
      out_llr <= '0;
      out_tag <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_res <= pe_res;
          s1_tag <= in_tag;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_llr <= sat_llr;
          out_tag <= s1_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_llr_fg_stage.sv
// tb_llr_fg_stage: table vectors, corner sequences and random traffic against a golden f/g model
module tb_llr_fg_stage;
  localparam int N = 16, W = 6, T = 8;
  typedef struct {logic [N*W-1:0] llr; logic [T-1:0] tag;} exp_t;
  typedef struct {logic mode; logic [2*N*W-1:0] alpha; logic [N-1:0] beta; logic [T-1:0] tag; logic [N*W-1:0] exp;} vec_t;
  logic clk = 0, rst, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [2*N*W-1:0] in_alpha;
  logic [N-1:0] in_beta;
  logic [T-1:0] in_tag, out_tag;
  logic [N*W-1:0] out_llr, prev_llr;
  logic prev_stall = 0;
  exp_t sbq[$];
  vec_t vecs[10];
  int checks = 0, errors = 0, outs = 0;
  always #5 clk = ~clk;
  llr_fg_stage dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_alpha(in_alpha), .in_beta(in_beta), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_llr(out_llr), .out_tag(out_tag));
  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask
  function automatic logic [N*W-1:0] model(input logic m, input logic [2*N*W-1:0] al, input logic [N-1:0] be);
    logic [N*W-1:0] r;
    int a, b, aa, bb, mn, v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      a = $signed(al[(2*N-1-i)*W +: W]);
      b = $signed(al[(N-1-i)*W +: W]);
      aa = a < 0 ? -a : a;
      bb = b < 0 ? -b : b;
      mn = aa < bb ? aa : bb;
      if (!m) v = ((a < 0) != (b < 0)) ? -mn : mn;
      else v = be[N-1-i] ? b - a : b + a;
      if (v > 31) v = 31;
      if (v < -31) v = -31;
      r[(N-1-i)*W +: W] = W'(v);
    end
    return r;
  endfunction
  function automatic logic [2*N*W-1:0] rep(input int a, input int b);
    logic [W-1:0] a6, b6;
    a6 = W'(a);
    b6 = W'(b);
    return {{N{a6}}, {N{b6}}};
  endfunction
  function automatic logic [N*W-1:0] rep1(input int e);
    logic [W-1:0] e6;
    e6 = W'(e);
    return {N{e6}};
  endfunction
  // inputs are set just after a falling edge; evaluate then advance one clock
  task automatic cycle(input logic [N*W-1:0] ex, output logic took);
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      outs++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out act=%h req=none", out_llr);
      end else begin
        e = sbq.pop_front();
        chk("out_llr", out_llr, e.llr);
        chk("out_tag", N*W'(out_tag), N*W'(e.tag));
      end
    end
    if (prev_stall) chk("stall_hold", out_llr, prev_llr);
    prev_stall = out_valid && !out_ready && !rst;
    prev_llr = out_llr;
    took = in_valid && in_ready && !rst;
    if (took) sbq.push_back('{ex, in_tag});
    @(negedge clk);
  endtask
  task automatic drain();
    logic t;
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) cycle('0, t);
    chk("drain_empty", N*W'(sbq.size()), '0);
    cycle('0, t);
  endtask
  initial begin
    logic t;
    logic [N*W-1:0] ex;
    logic [2*N*W-1:0] al;
    int c, sent, o0, drops;
    rst = 1; in_valid = 0; in_mode = 0; in_alpha = '0; in_beta = '0; in_tag = '0; out_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", N*W'(out_valid), '0);
    chk("rst_out_llr", out_llr, '0);
    chk("rst_out_tag", N*W'(out_tag), '0);
    rst = 0;
    @(negedge clk);
    #1 chk("in_ready_after_rst", N*W'(in_ready), N*W'(1));
    @(negedge clk);
    // latency: one f beat, visible exactly two edges after transfer
    in_valid = 1; in_mode = 0; in_alpha = rep(5, -3); in_tag = 8'h11;
    @(negedge clk);
    in_valid = 0;
    #1 chk("lat_t1_valid", N*W'(out_valid), '0);
    @(negedge clk);
    #1 chk("lat_t2_valid", N*W'(out_valid), N*W'(1));
    chk("lat_llr", out_llr, rep1(-3));
    chk("lat_tag", N*W'(out_tag), N*W'(8'h11));
    @(negedge clk);
    // vector table
    vecs[0] = '{0, rep(5, -3), 16'h0000, 8'h20, rep1(-3)};
    vecs[1] = '{1, rep(20, 20), 16'h0000, 8'h21, rep1(31)};
    vecs[2] = '{1, rep(20, 20), 16'hFFFF, 8'h22, rep1(0)};
    vecs[3] = '{1, rep(-32, 31), 16'hFFFF, 8'h23, rep1(31)};
    vecs[4] = '{0, rep(-32, -32), 16'h0000, 8'h24, rep1(31)};
    vecs[5] = '{1, rep(-32, -32), 16'h0000, 8'h25, rep1(-31)};
    vecs[6] = '{0, rep(0, -7), 16'h0000, 8'h26, rep1(0)};
    vecs[7] = '{0, rep(-4, -9), 16'h0000, 8'h27, rep1(4)};
    for (int i = 0; i < N; i++) begin
      al[(2*N-1-i)*W +: W] = W'(i - 8);
      al[(N-1-i)*W +: W] = W'(7 - i);
    end
    vecs[8] = '{1, al, 16'hA5A5, 8'h28, model(1, al, 16'hA5A5)};
    vecs[9] = '{0, al, 16'hA5A5, 8'h29, model(0, al, 16'hA5A5)};
    out_ready = 1;
    foreach (vecs[k]) begin
      in_valid = 1; in_mode = vecs[k].mode; in_alpha = vecs[k].alpha; in_beta = vecs[k].beta; in_tag = vecs[k].tag;
      cycle(vecs[k].exp, t);
      chk("table_accept", N*W'(t), N*W'(1));
    end
    drain();
    // backpressure: 6 back-to-back beats, out_ready low in cycles 3..6
    c = 0; sent = 0; drops = 0; o0 = outs;
    while (sent < 6 && c < 50) begin
      in_valid = 1; in_mode = 1; in_alpha = rep(sent + 1, 2 * sent); in_beta = 16'h0F0F; in_tag = 8'h40 + T'(sent);
      out_ready = !(c >= 3 && c <= 6);
      #0;
      if (!in_ready) drops++;
      cycle(model(1, in_alpha, in_beta), t);
      if (t) sent++;
      c++;
    end
    chk("bp_all_sent", N*W'(sent), N*W'(6));
    chk("bp_in_ready_dropped", N*W'(drops != 0), N*W'(1));
    drain();
    chk("bp_out_count", N*W'(outs - o0), N*W'(6));
    // random valid/ready traffic
    o0 = outs; sent = 0; c = 0;
    while (sent < 10000 && c < 60000) begin
      in_mode = $urandom_range(0, 1);
      in_alpha = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_beta = N'($urandom());
      in_tag = T'($urandom());
      ex = model(in_mode, in_alpha, in_beta);
      t = 0;
      while (!t && c < 60000) begin
        in_valid = ($urandom_range(0, 4) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        cycle(ex, t);
        c++;
      end
      sent++;
    end
    drain();
    chk("rand_out_count", N*W'(outs - o0), N*W'(10000));
    // reset with two beats in flight
    out_ready = 0; in_valid = 1; in_mode = 0; in_alpha = rep(9, 3); in_tag = 8'h77;
    cycle(rep1(3), t);
    cycle(rep1(3), t);
    in_valid = 0;
    #1 chk("pre_rst_valid", N*W'(out_valid), N*W'(1));
    rst = 1;
    @(negedge clk);
    #1 chk("rst_mid_valid", N*W'(out_valid), '0);
    sbq.delete();
    prev_stall = 0;
    rst = 0; out_ready = 1;
    @(negedge clk);
    o0 = outs;
    for (int k = 0; k < 6; k++) cycle('0, t);
    chk("no_stale_out", N*W'(outs - o0), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
